// File: rtl/regfile_mp_sb_pkg.sv
//==============================================================================
// regfile_pkg : shared constants and index helper for the register file
// Rev 1.0
//==============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int NREGS_DEF  = 32;

  function automatic int addr_w(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  localparam int ADDR_W_DEF = addr_w(NREGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

`default_nettype wire

// File: rtl/regfile_mp_sb_if.sv
//==============================================================================
// regfile_mp_sb_if : read/write/allocate bundle between pipeline and regfile
// Rev 1.0
//==============================================================================
`default_nettype none

interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  localparam int ADDR_W = addr_w(NREGS);

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic                  alloc_en;
  logic [ADDR_W-1:0]     alloc_addr;
  logic [NREGS-1:0]      busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

`default_nettype wire

// File: rtl/regfile_sb_core.sv
//==============================================================================
// regfile_sb_core : per-register busy scoreboard, allocate beats write-back
// Rev 1.0
//==============================================================================
`default_nettype none

module regfile_sb_core #(
  parameter int NREGS  = 32,
  parameter int NWR    = 2,
  parameter int ADDR_W = 5
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  input  wire logic [NWR-1:0]        wr_en,
  input  wire logic [NWR*ADDR_W-1:0] wr_addr,
  input  wire logic                  alloc_en,
  input  wire logic [ADDR_W-1:0]     alloc_addr,
  output logic      [NREGS-1:0]      busy_vec,
  output logic      [NREGS-1:0]      busy_next
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) clr_v[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
    end
    if (alloc_en) set_v[alloc_addr] = 1'b1;
    // set applied after clear so a same-cycle allocate keeps the register busy
    busy_next    = (busy_r & ~clr_v) | set_v;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_r <= '0;
    else        busy_r <= busy_next;
  end

  assign busy_vec = busy_r;

endmodule

`default_nettype wire

// File: rtl/regfile_mp_sb.sv
//==============================================================================
// regfile_mp_sb : multi-port register file with write bypass and busy scoreboard
// Rev 1.0
//==============================================================================
`default_nettype none

module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input wire logic       clock,
  input wire logic       reset,
  regfile_mp_sb_if.slave bus
);

  localparam int ADDR_W = addr_w(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy_r;
  logic [NREGS-1:0]  busy_next;

  regfile_sb_core #(
    .NREGS  (NREGS),
    .NWR    (NWR),
    .ADDR_W (ADDR_W)
  ) u_sb_core (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .busy_vec   (busy_r),
    .busy_next  (busy_next)
  );

  assign bus.busy_vec = busy_r;

  // ascending port order: the youngest write port lands last and wins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] != '0))
          regs[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= bus.wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              b;

    assign ra = bus.rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      d = regs[ra];
      b = busy_r[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] == ra))
            d = bus.wr_data[j*DATA_W +: DATA_W];
        end
        b = busy_next[ra];
      end
      // x0 reads as zero, and bypassed values must not leak out during reset
      if ((ra == '0) || !reset) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign bus.rd_data[i*DATA_W +: DATA_W] = d;
    assign bus.rd_busy[i]                  = b;
  end

endmodule

`default_nettype wire
